// File: rtl/hssi_tc_mailbox_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hssi_tc_mailbox_bridge : host mailbox issuing single register reads/writes
//                          to one of NUM_PORTS HSSI traffic controllers.
// Rev 1.0
// ----------------------------------------------------------------------------
module hssi_tc_mailbox_bridge #(
  parameter int NUM_PORTS   = 16,
  parameter int PORT_W      = 4,
  parameter int TC_ADDR_W   = 16,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 csr_wr,
  input  logic                 csr_rd,
  input  logic [3:0]           csr_addr,
  input  logic [DATA_W-1:0]    csr_wrdata,
  output logic [DATA_W-1:0]    csr_rddata,
  output logic                 csr_rdvalid,
  input  logic [PORT_W-1:0]    port_sel,
  output logic                 tc_req,
  output logic                 tc_we,
  output logic [PORT_W-1:0]    tc_port,
  output logic [TC_ADDR_W-1:0] tc_addr,
  output logic [DATA_W-1:0]    tc_wdata,
  input  logic                 tc_ack,
  input  logic [DATA_W-1:0]    tc_rdata
);

  localparam int                CNT_W       = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  C_CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [PORT_W:0]   C_NUM_PORTS = (PORT_W + 1)'(NUM_PORTS);
  localparam logic [1:0]        C_CMD_RD    = 2'd1;
  localparam logic [1:0]        C_CMD_WR    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CPL  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_address;
  logic [DATA_W-1:0]  r_wrdata;
  logic [DATA_W-1:0]  r_rddata;
  logic [1:0]         r_last;
  logic               r_busy;
  logic               r_ack;
  logic               r_tmo;
  logic               r_perr;
  logic               r_ovr;

  logic               w_wr_cmd;
  logic               w_cmd_go;
  logic               w_cmd_noop;
  logic               w_port_bad;
  logic               w_timeout;
  logic [DATA_W-1:0]  w_cmd_word;

  assign w_wr_cmd   = csr_wr && (csr_addr == 4'h0);
  assign w_cmd_go   = w_wr_cmd && ((csr_wrdata[1:0] == C_CMD_RD) || (csr_wrdata[1:0] == C_CMD_WR));
  assign w_cmd_noop = w_wr_cmd && !w_cmd_go;
  assign w_port_bad = {1'b0, port_sel} >= C_NUM_PORTS;
  assign w_timeout  = (r_cnt == C_CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    tc_req      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_go) w_state_nxt = w_port_bad ? ST_CPL : ST_REQ;
      end
      ST_REQ: begin
        tc_req = 1'b1;
        if (tc_ack || w_timeout) w_state_nxt = ST_CPL;
      end
      ST_CPL:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_address <= '0;
      r_wrdata  <= '0;
      r_rddata  <= '0;
      r_last    <= '0;
      r_busy    <= 1'b0;
      r_ack     <= 1'b0;
      r_tmo     <= 1'b0;
      r_perr    <= 1'b0;
      r_ovr     <= 1'b0;
      tc_we     <= 1'b0;
      tc_port   <= '0;
      tc_addr   <= '0;
      tc_wdata  <= '0;
    end else begin
      // ADDRESS/WRDATA stay writable while busy; the request uses its latched copy.
      if (csr_wr && (csr_addr == 4'h4)) r_address <= csr_wrdata;
      if (csr_wr && (csr_addr == 4'hC)) r_wrdata  <= csr_wrdata;

      r_cnt <= (r_state == ST_REQ) ? r_cnt + 1'b1 : '0;

      if (w_cmd_noop) begin
        r_ack  <= 1'b0;
        r_tmo  <= 1'b0;
        r_perr <= 1'b0;
        r_ovr  <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_cmd_go) begin
            r_last   <= csr_wrdata[1:0];
            tc_we    <= (csr_wrdata[1:0] == C_CMD_WR);
            tc_port  <= port_sel;
            tc_addr  <= r_address[TC_ADDR_W-1:0];
            tc_wdata <= r_wrdata;
            r_busy   <= 1'b1;
            r_ack    <= 1'b0;
            r_tmo    <= 1'b0;
            r_perr   <= w_port_bad;
          end
        end
        ST_REQ: begin
          if (w_cmd_go) r_ovr <= 1'b1;
          if (tc_ack) begin
            if (!tc_we) r_rddata <= tc_rdata;
          end else if (w_timeout) begin
            r_tmo    <= 1'b1;
            r_rddata <= '1;
          end
        end
        ST_CPL: begin
          if (w_cmd_go) r_ovr <= 1'b1;
          r_ack  <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_cmd_word      = '0;
    w_cmd_word[6:0] = {r_ovr, r_perr, r_tmo, r_ack, r_busy, r_last};
  end

  // Read mux samples pre-write register values, so a same-cycle write is not visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      csr_rddata  <= '0;
      csr_rdvalid <= 1'b0;
    end else begin
      csr_rdvalid <= csr_rd;
      if (csr_rd) begin
        case (csr_addr)
          4'h0:    csr_rddata <= w_cmd_word;
          4'h4:    csr_rddata <= r_address;
          4'h8:    csr_rddata <= r_rddata;
          4'hC:    csr_rddata <= r_wrdata;
          default: csr_rddata <= '0;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hssi_tc_mailbox_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hssi_tc_mailbox_bridge : directed + randomized bench with a transaction-level model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_hssi_tc_mailbox_bridge;

  localparam int NP = 6;
  localparam int PW = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          csr_wr, csr_rd;
  logic [3:0]    csr_addr;
  logic [DW-1:0] csr_wrdata, csr_rddata;
  logic          csr_rdvalid;
  logic [PW-1:0] port_sel;
  logic          tc_req, tc_we, tc_ack;
  logic [PW-1:0] tc_port;
  logic [AW-1:0] tc_addr;
  logic [DW-1:0] tc_wdata, tc_rdata;

  always #5 clk = ~clk;

  hssi_tc_mailbox_bridge #(
    .NUM_PORTS(NP), .PORT_W(PW), .TC_ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .csr_wr(csr_wr), .csr_rd(csr_rd), .csr_addr(csr_addr),
    .csr_wrdata(csr_wrdata), .csr_rddata(csr_rddata), .csr_rdvalid(csr_rdvalid),
    .port_sel(port_sel), .tc_req(tc_req), .tc_we(tc_we), .tc_port(tc_port),
    .tc_addr(tc_addr), .tc_wdata(tc_wdata), .tc_ack(tc_ack), .tc_rdata(tc_rdata)
  );

  int checks   = 0;
  int failures = 0;

  // Mailbox contents as the host should see them
  logic [31:0] m_address, m_wrdata, m_rddata;
  logic [1:0]  m_last;
  logic        m_ack, m_tmo, m_perr, m_ovr;

  function automatic logic [31:0] m_cmd();
    return {25'd0, m_ovr, m_perr, m_tmo, m_ack, 1'b0, m_last};
  endfunction

  task automatic model_reset();
    m_address = '0; m_wrdata = '0; m_rddata = '0; m_last = '0;
    m_ack = 0; m_tmo = 0; m_perr = 0; m_ovr = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk); csr_wr = 1; csr_addr = a; csr_wrdata = d;
    @(negedge clk); csr_wr = 0;
    if (a == 4'h4) m_address = d;
    if (a == 4'hC) m_wrdata = d;
    if (a == 4'h0 && (d[1:0] == 2'd0 || d[1:0] == 2'd3)) begin
      m_ack = 0; m_tmo = 0; m_perr = 0; m_ovr = 0;
    end
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    @(negedge clk); csr_rd = 1; csr_addr = a;
    @(negedge clk); csr_rd = 0;
    check({tag, "_vld"}, {31'd0, csr_rdvalid}, 32'd1);
    check(tag, csr_rddata, exp);
  endtask

  // One mailbox command; d = req cycles before ack (d >= TO means no ack).
  task automatic run_txn(input logic [1:0] cmd, input int port, input logic [31:0] addr,
                         input logic [31:0] wdata, input int d, input logic [31:0] rdat,
                         input bit dup);
    int  nreq;
    int  exp_req;
    bit  bad;
    csr_write(4'h4, addr);
    csr_write(4'hC, wdata);
    port_sel = port[PW-1:0];
    bad = (port >= NP);
    @(negedge clk); csr_wr = 1; csr_addr = 4'h0; csr_wrdata = {30'd0, cmd};
    @(negedge clk); csr_wr = 0;
    nreq = 0;
    for (int i = 0; i < TO + 6; i++) begin
      if (tc_req) begin
        if (nreq == 0) begin
          check("tc_we",    {31'd0, tc_we}, {31'd0, cmd == 2'd2});
          check("tc_port",  {28'd0, tc_port}, {28'd0, port[PW-1:0]});
          check("tc_addr",  {16'd0, tc_addr}, {16'd0, addr[AW-1:0]});
          check("tc_wdata", tc_wdata, wdata);
        end
        if (nreq == d) begin tc_ack = 1; tc_rdata = rdat; end
        if (dup && (nreq == 1 || nreq == d)) begin
          csr_wr = 1; csr_addr = 4'h0; csr_wrdata = 32'd2;
        end
        nreq++;
      end
      @(negedge clk); tc_ack = 0; csr_wr = 0;
    end
    exp_req = bad ? 0 : ((d < TO) ? d + 1 : TO);
    check("req_cycles", nreq, exp_req);
    m_last = cmd; m_ack = 1; m_perr = bad; m_tmo = !bad && (d >= TO);
    if (dup && !bad) m_ovr = 1;
    if (!bad) begin
      if (d >= TO)         m_rddata = '1;
      else if (cmd == 2'd1) m_rddata = rdat;
    end
    rd_check("cmd", 4'h0, m_cmd());
    rd_check("rddata", 4'h8, m_rddata);
  endtask

  initial begin
    logic [31:0] v;
    logic [1:0]  c;
    int          p, d;
    rst = 1; csr_wr = 0; csr_rd = 0; csr_addr = 0; csr_wrdata = 0;
    port_sel = 0; tc_ack = 0; tc_rdata = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 0;
    check("rst_outs", {tc_req, tc_we, tc_port, tc_addr, csr_rdvalid}, 0);
    check("rst_tc_wdata", tc_wdata, 0);
    rd_check("rst_cmd", 4'h0, 0);
    rd_check("rst_address", 4'h4, 0);
    rd_check("rst_wrdata", 4'hC, 0);
    rd_check("rst_rddata", 4'h8, 0);

    run_txn(2'd2, 2, 32'h0D, 32'h40, 3, 32'h0, 0);
    run_txn(2'd1, 5, 32'h101, 32'h0, 10, 32'hCAFE_0123, 0);
    run_txn(2'd1, 1, 32'h22, 32'h0, 99, 32'h0, 0);
    run_txn(2'd1, 7, 32'h33, 32'h0, 2, 32'h1234, 0);
    run_txn(2'd2, 3, 32'h44, 32'h55, 3, 32'h0, 1);
    csr_write(4'h0, 32'd0);
    rd_check("noop_clear", 4'h0, m_cmd());

    // RDDATA is read-only
    csr_write(4'h8, 32'h1357_9BDF);
    rd_check("rddata_ro", 4'h8, m_rddata);

    // Simultaneous read and write returns the old value
    @(negedge clk); csr_wr = 1; csr_rd = 1; csr_addr = 4'h4; csr_wrdata = 32'hA5A5_0F0F;
    @(negedge clk); csr_wr = 0; csr_rd = 0;
    check("rdwr_old", csr_rddata, m_address);
    m_address = 32'hA5A5_0F0F;
    rd_check("rdwr_new", 4'h4, m_address);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        v = $urandom;
        v[1:0] = ($urandom_range(0, 1) != 0) ? 2'd0 : 2'd3;
        csr_write(4'h0, v);
      end
      c = ($urandom_range(0, 1) != 0) ? 2'd2 : 2'd1;
      p = $urandom_range(0, 7);
      d = $urandom_range(0, 20);
      run_txn(c, p, $urandom, $urandom, d, $urandom, $urandom_range(0, 4) == 0);
      rd_check("rand_address", 4'h4, m_address);
    end

    // Reset in the middle of a request
    csr_write(4'h4, 32'h55);
    port_sel = 4'd1;
    @(negedge clk); csr_wr = 1; csr_addr = 4'h0; csr_wrdata = 32'd1;
    @(negedge clk); csr_wr = 0;
    repeat (3) @(negedge clk);
    check("mid_req", {31'd0, tc_req}, 1);
    rst = 1;
    @(negedge clk);
    check("rst_req_drop", {31'd0, tc_req}, 0);
    rst = 0;
    model_reset();
    rd_check("rst2_cmd", 4'h0, 0);
    rd_check("rst2_address", 4'h4, 0);
    @(negedge clk); tc_ack = 1; tc_rdata = 32'hDEAD_BEEF;
    @(negedge clk); tc_ack = 0;
    check("stray_req", {31'd0, tc_req}, 0);
    rd_check("stray_rddata", 4'h8, 0);
    rd_check("stray_cmd", 4'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
